// File: rtl/risc_v_decode_stage_if.sv
// Handshake and decoded-control bundle between fetch, the decode stage and execute.
// The slave modport is the decode stage's view; master is the fetch/execute side.
interface risc_v_decode_stage_if #(
    parameter int WORD_LENGTH       = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int ILLEGAL_CNT_WIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  instr;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [3:0]                   alu_op;
    logic                         cin;
    logic                         is_I_type;
    logic                         reg_write_en;
    logic                         mem_read;
    logic                         mem_write;
    logic                         branch;
    logic                         jump;
    logic [REG_ADDR_WIDTH-1:0]    rd;
    logic [REG_ADDR_WIDTH-1:0]    rs1;
    logic [REG_ADDR_WIDTH-1:0]    rs2;
    logic [WORD_LENGTH-1:0]       imm;
    logic                         illegal;
    logic [ILLEGAL_CNT_WIDTH-1:0] illegal_count;

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, alu_op, cin, is_I_type, reg_write_en,
               mem_read, mem_write, branch, jump, rd, rs1, rs2, imm,
               illegal, illegal_count
    );

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, alu_op, cin, is_I_type, reg_write_en,
               mem_read, mem_write, branch, jump, rd, rs1, rs2, imm,
               illegal, illegal_count
    );
endinterface

// File: rtl/risc_v_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into one registered,
// valid/ready handshaked entry for execute, with illegal-encoding detection and counting.
module risc_v_decode_stage #(
    parameter int WORD_LENGTH       = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int ILLEGAL_CNT_WIDTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    risc_v_decode_stage_if.slave bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Every immediate is first formed as a 32-bit two's-complement value, then widened.
    function automatic logic signed [WORD_LENGTH-1:0] sext32(input logic [31:0] v);
        logic signed [WORD_LENGTH-1:0] r;
        r = WORD_LENGTH'($signed(v));
        return r;
    endfunction

    function automatic logic [3:0] funct3_alu(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [ILLEGAL_CNT_WIDTH-1:0] sat_inc(
        input logic [ILLEGAL_CNT_WIDTH-1:0] c
    );
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [31:0] raw_i;
    logic [31:0] raw_s;
    logic [31:0] raw_b;
    logic [31:0] raw_j;
    logic [31:0] raw_u;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    assign raw_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign raw_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign raw_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};
    assign raw_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                    bus.instr[20], bus.instr[30:21], 1'b0};
    assign raw_u = {bus.instr[31:12], 12'h000};

    // ---- stage p0: combinational decode of the presented instruction ----
    logic [3:0]                    alu_p0;
    logic                          cin_p0;
    logic                          isi_p0;
    logic                          rw_p0;
    logic                          mr_p0;
    logic                          mw_p0;
    logic                          br_p0;
    logic                          jp_p0;
    logic                          ill_p0;
    logic signed [WORD_LENGTH-1:0] imm_p0;
    logic [REG_ADDR_WIDTH-1:0]     rd_p0;
    logic [REG_ADDR_WIDTH-1:0]     rs1_p0;
    logic [REG_ADDR_WIDTH-1:0]     rs2_p0;

    assign rd_p0  = REG_ADDR_WIDTH'(bus.instr[11:7]);
    assign rs1_p0 = REG_ADDR_WIDTH'(bus.instr[19:15]);
    assign rs2_p0 = REG_ADDR_WIDTH'(bus.instr[24:20]);

    always_comb begin
        alu_p0 = ALU_ADD;
        cin_p0 = 1'b0;
        isi_p0 = 1'b0;
        rw_p0  = 1'b0;
        mr_p0  = 1'b0;
        mw_p0  = 1'b0;
        br_p0  = 1'b0;
        jp_p0  = 1'b0;
        ill_p0 = 1'b0;
        imm_p0 = sext32(raw_i);

        case (opcode)
            OPC_OP: begin
                imm_p0 = '0;
                rw_p0  = 1'b1;
                if (funct7 == F7_BASE) begin
                    alu_p0 = funct3_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    cin_p0 = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu_p0 = ALU_SRA;
                end else begin
                    ill_p0 = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                isi_p0 = 1'b1;
                rw_p0  = 1'b1;
                alu_p0 = funct3_alu(funct3);
                // Only the shifts give meaning to imm[11:5]; bit 30 selects srai.
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    ill_p0 = 1'b1;
                end
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        alu_p0 = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        ill_p0 = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                isi_p0 = 1'b1;
                mr_p0  = 1'b1;
                rw_p0  = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    ill_p0 = 1'b1;
                end
            end
            OPC_STORE: begin
                isi_p0 = 1'b1;
                mw_p0  = 1'b1;
                imm_p0 = sext32(raw_s);
                if (funct3 > 3'b010) begin
                    ill_p0 = 1'b1;
                end
            end
            OPC_BRANCH: begin
                br_p0  = 1'b1;
                imm_p0 = sext32(raw_b);
                case (funct3)
                    3'b000, 3'b001: cin_p0 = 1'b1;
                    3'b100, 3'b101: alu_p0 = ALU_SLT;
                    3'b110, 3'b111: alu_p0 = ALU_SLTU;
                    default:        ill_p0 = 1'b1;
                endcase
            end
            OPC_JAL: begin
                jp_p0  = 1'b1;
                rw_p0  = 1'b1;
                imm_p0 = sext32(raw_j);
            end
            OPC_JALR: begin
                jp_p0  = 1'b1;
                isi_p0 = 1'b1;
                rw_p0  = 1'b1;
                if (funct3 != 3'b000) begin
                    ill_p0 = 1'b1;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                rw_p0  = 1'b1;
                isi_p0 = 1'b1;
                imm_p0 = sext32(raw_u);
            end
            default: begin
                ill_p0 = 1'b1;
            end
        endcase

        // An illegal entry must not trigger any side effect downstream.
        if (ill_p0) begin
            alu_p0 = '0;
            cin_p0 = 1'b0;
            isi_p0 = 1'b0;
            rw_p0  = 1'b0;
            mr_p0  = 1'b0;
            mw_p0  = 1'b0;
            br_p0  = 1'b0;
            jp_p0  = 1'b0;
        end
    end

    // ---- stage p1: registered entry presented to execute ----
    logic                          vld_p1;
    logic [3:0]                    alu_p1;
    logic                          cin_p1;
    logic                          isi_p1;
    logic                          rw_p1;
    logic                          mr_p1;
    logic                          mw_p1;
    logic                          br_p1;
    logic                          jp_p1;
    logic                          ill_p1;
    logic signed [WORD_LENGTH-1:0] imm_p1;
    logic [REG_ADDR_WIDTH-1:0]     rd_p1;
    logic [REG_ADDR_WIDTH-1:0]     rs1_p1;
    logic [REG_ADDR_WIDTH-1:0]     rs2_p1;
    logic [ILLEGAL_CNT_WIDTH-1:0]  ill_cnt;
    logic                          ready;
    logic                          accept;

    // Flush blocks acceptance in the same cycle so the discarded slot is not refilled.
    assign ready  = !reset && !bus.flush && (!vld_p1 || bus.out_ready);
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            alu_p1  <= '0;
            cin_p1  <= 1'b0;
            isi_p1  <= 1'b0;
            rw_p1   <= 1'b0;
            mr_p1   <= 1'b0;
            mw_p1   <= 1'b0;
            br_p1   <= 1'b0;
            jp_p1   <= 1'b0;
            ill_p1  <= 1'b0;
            imm_p1  <= '0;
            rd_p1   <= '0;
            rs1_p1  <= '0;
            rs2_p1  <= '0;
            ill_cnt <= '0;
        end else begin
            if (bus.flush) begin
                vld_p1 <= 1'b0;
            end else if (accept) begin
                vld_p1 <= 1'b1;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end

            if (accept) begin
                alu_p1 <= alu_p0;
                cin_p1 <= cin_p0;
                isi_p1 <= isi_p0;
                rw_p1  <= rw_p0;
                mr_p1  <= mr_p0;
                mw_p1  <= mw_p0;
                br_p1  <= br_p0;
                jp_p1  <= jp_p0;
                ill_p1 <= ill_p0;
                imm_p1 <= imm_p0;
                rd_p1  <= rd_p0;
                rs1_p1 <= rs1_p0;
                rs2_p1 <= rs2_p0;
                if (ill_p0) begin
                    ill_cnt <= sat_inc(ill_cnt);
                end
            end
        end
    end

    assign bus.in_ready      = ready;
    assign bus.out_valid     = vld_p1;
    assign bus.alu_op        = alu_p1;
    assign bus.cin           = cin_p1;
    assign bus.is_I_type     = isi_p1;
    assign bus.reg_write_en  = rw_p1;
    assign bus.mem_read      = mr_p1;
    assign bus.mem_write     = mw_p1;
    assign bus.branch        = br_p1;
    assign bus.jump          = jp_p1;
    assign bus.rd            = rd_p1;
    assign bus.rs1           = rs1_p1;
    assign bus.rs2           = rs2_p1;
    assign bus.imm           = imm_p1;
    assign bus.illegal       = ill_p1;
    assign bus.illegal_count = ill_cnt;

endmodule

// File: tb/tb_risc_v_decode_stage.sv
// Scoreboard bench for risc_v_decode_stage: directed cases followed by randomized traffic,
// with expected entries produced by an instruction-level reference model.
module tb_risc_v_decode_stage;
    localparam int WL = 32;
    localparam int RA = 5;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    risc_v_decode_stage_if #(.WORD_LENGTH(WL), .REG_ADDR_WIDTH(RA), .ILLEGAL_CNT_WIDTH(CW)) bus ();

    risc_v_decode_stage #(.WORD_LENGTH(WL), .REG_ADDR_WIDTH(RA), .ILLEGAL_CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  alu;
        logic        cin;
        logic        isi;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    dec_t    exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    logic [CW-1:0] exp_cnt = '0;
    bit      started = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // ALU code: funct3 names add..srl map onto 0..5; or/and are 8/7.
    function automatic logic [3:0] f3op(input logic [2:0] f3);
        if (f3 == 3'd6) return 4'd8;
        if (f3 == 3'd7) return 4'd7;
        return {1'b0, f3};
    endfunction

    function automatic dec_t model(input logic [31:0] i);
        dec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        d = '0;
        d.rd  = i[11:7];
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.imm = {{20{i[31]}}, i[31:20]};
        case (i[6:0])
            7'h33: begin
                d.imm = '0;
                d.rw  = 1'b1;
                if (f7 == 7'h00) d.alu = f3op(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) d.cin = 1'b1;
                else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd6;
                else d.ill = 1'b1;
            end
            7'h13: begin
                d.isi = 1'b1;
                d.rw  = 1'b1;
                d.alu = f3op(f3);
                if (f3 == 3'd1) d.ill = (f7 != 7'h00);
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) d.alu = 4'd6;
                    else d.ill = (f7 != 7'h00);
                end
            end
            7'h03: begin
                d.isi = 1'b1; d.mr = 1'b1; d.rw = 1'b1;
                d.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin
                d.isi = 1'b1; d.mw = 1'b1;
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                d.ill = (f3 > 3'd2);
            end
            7'h63: begin
                d.br  = 1'b1;
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                d.cin = (f3[2] == 1'b0);
                d.alu = f3[2] ? (f3[1] ? 4'd3 : 4'd2) : 4'd0;
                d.ill = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h6F: begin
                d.jp = 1'b1; d.rw = 1'b1;
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: begin
                d.jp = 1'b1; d.isi = 1'b1; d.rw = 1'b1;
                d.ill = (f3 != 3'd0);
            end
            7'h37, 7'h17: begin
                d.rw = 1'b1; d.isi = 1'b1;
                d.imm = {i[31:12], 12'h000};
            end
            default: d.ill = 1'b1;
        endcase
        if (d.ill) {d.alu, d.cin, d.isi, d.rw, d.mr, d.mw, d.br, d.jp} = '0;
        return d;
    endfunction

    function automatic dec_t actual();
        dec_t a;
        a.alu = bus.alu_op;      a.cin = bus.cin;        a.isi = bus.is_I_type;
        a.rw  = bus.reg_write_en; a.mr = bus.mem_read;   a.mw  = bus.mem_write;
        a.br  = bus.branch;      a.jp  = bus.jump;       a.rd  = bus.rd;
        a.rs1 = bus.rs1;         a.rs2 = bus.rs2;        a.imm = bus.imm;
        a.ill = bus.illegal;
        return a;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel;
        int k;
        r = $urandom();
        sel = $urandom_range(0, 10);
        case (sel)
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h6F;
            6: r[6:0] = 7'h67;
            7: r[6:0] = 7'h37;
            8: r[6:0] = 7'h17;
            9: r[6:0] = 7'h13;
            default: ;
        endcase
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            k = $urandom_range(0, 3);
            if (k < 2) r[31:25] = 7'h00;
            else if (k == 2) r[31:25] = 7'h20;
        end
        return r;
    endfunction

    // One clock of stimulus; model-side expectations are updated at +3 from the edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic fl, input logic rs);
        logic exp_rdy;
        dec_t e;
        @(posedge clk);
        #1;
        if (started) chk("illegal_count", 64'(bus.illegal_count), 64'(exp_cnt));
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
        reset         = rs;
        #2;
        exp_rdy = !rs && !fl && (exp_q.size() == 0 || ordy);
        if (started) begin
            chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        end
        if (rs) begin
            exp_q.delete();
            exp_cnt = '0;
            started = 1;
        end else if (fl) begin
            exp_q.delete();
        end else if (iv && exp_rdy) begin
            e = model(ins);
            exp_q.push_back(e);
            if (e.ill && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    task automatic send_hold(input logic [31:0] ins);
        step(1'b1, ins, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every consumed entry and checks stall stability.
    initial begin : monitor
        dec_t e;
        dec_t snap;
        bit   prev_stall;
        prev_stall = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (prev_stall)
                    chk("stall_stable", {4'h0, bus.out_valid, actual()}, {4'h0, 1'b1, snap});
                prev_stall = bus.out_valid && !bus.out_ready && !bus.flush && !reset;
                snap = actual();
                if (bus.out_valid && bus.out_ready && !bus.flush && !reset) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: actual=%0h expected=none", actual());
                    end else begin
                        e = exp_q.pop_front();
                        n_checks--;
                        chk("decode", 64'(actual()), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        reset         = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("reset_state", {4'h0, bus.out_valid, actual()}, 64'h0);
        chk("ready_after_reset", 64'(bus.in_ready), 64'h1);

        // add x3,x1,x2
        send_hold(32'h002081B3);
        chk("add_fields", {bus.out_valid, bus.alu_op, bus.cin, bus.rd, bus.rs1, bus.rs2,
                           bus.reg_write_en, bus.illegal},
                          {1'b1, 4'd0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0});

        // sub stalled for 3 cycles, then consumed while addi is accepted
        step(1'b1, 32'h402081B3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hFFF00293, 1'b0, 1'b0, 1'b0);
            chk("sub_stall", {bus.in_ready, bus.out_valid, bus.cin}, 3'b011);
        end
        step(1'b1, 32'hFFF00293, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("addi", {bus.is_I_type, bus.cin, bus.imm}, {1'b1, 1'b0, 32'hFFFFFFFF});

        send_hold(32'h4032D293);
        chk("srai_alu", 64'(bus.alu_op), 64'd6);
        send_hold(32'h40329293);
        chk("slli_bad", {bus.illegal, bus.reg_write_en, bus.is_I_type}, 3'b100);
        send_hold(32'h0080A303);
        chk("lw", {bus.mem_read, bus.mem_write, bus.reg_write_en, bus.imm}, {3'b101, 32'd8});
        send_hold(32'h0060A423);
        chk("sw", {bus.mem_read, bus.mem_write, bus.reg_write_en, bus.imm}, {3'b010, 32'd8});
        send_hold(32'hFE000EE3);
        chk("beq", {bus.branch, bus.cin, bus.alu_op, bus.imm}, {1'b1, 1'b1, 4'd0, 32'hFFFFFFFC});
        send_hold(32'h008000EF);
        chk("jal", {bus.jump, bus.reg_write_en, bus.rd, bus.imm}, {2'b11, 5'd1, 32'd8});
        send_hold(32'h123452B7);
        chk("lui", {bus.is_I_type, bus.reg_write_en, bus.imm}, {2'b11, 32'h12345000});

        // counter saturation on a long run of all-zero words
        for (int i = 0; i < 300; i++) step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("cnt_saturated", 64'(bus.illegal_count), 64'hFF);
        chk("zero_enables", {bus.illegal, bus.reg_write_en, bus.mem_read, bus.mem_write,
                             bus.branch, bus.jump, bus.cin, bus.is_I_type, bus.alu_op}, 12'h800);

        // flush while holding an entry and fetch is offering another
        step(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0080A303, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_drop", {bus.out_valid, bus.illegal_count}, {1'b0, 8'hFF});

        // reset during a stall
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_mid_stall", {bus.out_valid, bus.illegal_count}, 9'h0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
